// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: decodes two-byte UART commands into a period-aligned
// modulator angle and a gate-drive enable, and counts discarded frames.
// Build option: define UART_CMD_ECHO_EN to echo each accepted frame back
// through uart_tx. Without it start_tx and tx_data are tied low.
//
// receive FSM
//   state   | meaning
//   WAIT_HI | idle, next byte is byte0 {cmd, arg[11:8]}
//   WAIT_LO | byte0 held, waiting for byte1 under the inter-byte timeout
//   DECODE  | one cycle: act on the complete frame or discard it
// echo FSM (UART_CMD_ECHO_EN only)
//   state     | meaning
//   E_IDLE    | no echo in progress
//   E_HI      | launch byte0 once uart_tx is free
//   E_WAIT_HI | wait for tx_busy to rise then fall
//   E_LO      | launch byte1 once uart_tx is free
//   E_WAIT_LO | wait for tx_busy to rise then fall
module uart_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int ANGLE_MAX      = 3599
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        rx_parity_err,
    input  logic        period_start,
    input  logic        tx_busy,
    output logic        start_tx,
    output logic [7:0]  tx_data,
    output logic [11:0] angle,
    output logic        angle_upd,
    output logic        out_en,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {WAIT_HI, WAIT_LO, DECODE} rx_state_t;

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [12:0] ANGLE_LIM = 13'(ANGLE_MAX);

    rx_state_t   rx_state, rx_next;
    logic        rx_done_q;
    logic        byte_stb;
    logic [TW-1:0] timer;
    logic [7:0]  hi_q, lo_q;
    logic [3:0]  cmd;
    logic [11:0] arg;
    logic        discard, set_angle, set_on, set_off, frame_ok;
    logic [11:0] shadow;
    logic        pending;

    // A held rx_done level is a single byte: only its rising edge counts.
    assign byte_stb = rx_done & ~rx_done_q;
    assign cmd      = hi_q[7:4];
    assign arg      = {hi_q[3:0], lo_q};
    assign frame_ok = set_angle | set_on | set_off;

    // Receive next-state and the one-cycle decode/discard strobes.
    always_comb begin
        rx_next   = rx_state;
        discard   = 1'b0;
        set_angle = 1'b0;
        set_on    = 1'b0;
        set_off   = 1'b0;
        case (rx_state)
            WAIT_HI: begin
                if (byte_stb) begin
                    if (rx_parity_err) discard = 1'b1;
                    else               rx_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (byte_stb) begin
                    if (rx_parity_err) begin
                        discard = 1'b1;
                        rx_next = WAIT_HI;
                    end else begin
                        rx_next = DECODE;
                    end
                end else if (timer == '0) begin
                    discard = 1'b1;
                    rx_next = WAIT_HI;
                end
            end
            DECODE: begin
                rx_next = WAIT_HI;
                case (cmd)
                    4'h0:    if ({1'b0, arg} <= ANGLE_LIM) set_angle = 1'b1;
                             else                          discard   = 1'b1;
                    4'h1:    set_on  = 1'b1;
                    4'h2:    set_off = 1'b1;
                    default: discard = 1'b1;
                endcase
            end
            default: rx_next = WAIT_HI;
        endcase
    end

    // Receive state, byte capture and inter-byte timeout down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= WAIT_HI;
            rx_done_q <= 1'b0;
            timer     <= '0;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
        end else begin
            rx_state  <= rx_next;
            rx_done_q <= rx_done;
            if (rx_state == WAIT_HI && rx_next == WAIT_LO) begin
                hi_q  <= rx_data;
                timer <= TW'(TIMEOUT_CYCLES);
            end else if (rx_state == WAIT_LO && timer != '0) begin
                timer <= timer - TW'(1);
            end
            if (rx_state == WAIT_LO && rx_next == DECODE) lo_q <= rx_data;
        end
    end

    // Outputs: period-aligned angle apply, enable, error pulse and counter.
    // Apply happens before the shadow write so a same-cycle accept stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= 12'h000;
            pending   <= 1'b0;
            angle     <= 12'h000;
            angle_upd <= 1'b0;
            out_en    <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else begin
            angle_upd <= 1'b0;
            frame_err <= discard;
            if (discard && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (period_start && pending) begin
                angle     <= shadow;
                angle_upd <= 1'b1;
                pending   <= 1'b0;
            end
            if (set_angle) begin
                shadow  <= arg;
                pending <= 1'b1;
            end
            if (set_on)       out_en <= 1'b1;
            else if (set_off) out_en <= 1'b0;
        end
    end

`ifdef UART_CMD_ECHO_EN
    typedef enum logic [2:0] {E_IDLE, E_HI, E_WAIT_HI, E_LO, E_WAIT_LO} echo_state_t;

    echo_state_t e_state, e_next;
    logic        busy_seen, busy_done, send_now;
    logic [7:0]  echo_hi, echo_lo;

    assign busy_done = busy_seen & ~tx_busy;

    // Echo next-state: launch a byte when uart_tx is free, then ride out its busy pulse.
    always_comb begin
        e_next   = e_state;
        send_now = 1'b0;
        case (e_state)
            E_IDLE:    if (frame_ok) e_next = E_HI;
            E_HI:      if (!tx_busy) begin
                           send_now = 1'b1;
                           e_next   = E_WAIT_HI;
                       end
            E_WAIT_HI: if (busy_done) e_next = E_LO;
            E_LO:      if (!tx_busy) begin
                           send_now = 1'b1;
                           e_next   = E_WAIT_LO;
                       end
            E_WAIT_LO: if (busy_done) e_next = E_IDLE;
            default:   e_next = E_IDLE;
        endcase
    end

    // Echo state, frame snapshot and registered uart_tx handshake.
    // Frames accepted while an echo is running are simply not echoed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_state   <= E_IDLE;
            busy_seen <= 1'b0;
            echo_hi   <= 8'h00;
            echo_lo   <= 8'h00;
            start_tx  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            e_state   <= e_next;
            start_tx  <= send_now;
            busy_seen <= (e_state == E_WAIT_HI || e_state == E_WAIT_LO) && tx_busy;
            if (e_state == E_IDLE && frame_ok) begin
                echo_hi <= hi_q;
                echo_lo <= lo_q;
            end
            if (send_now) tx_data <= (e_state == E_HI) ? echo_hi : echo_lo;
        end
    end
`else
    logic unused_echo;

    assign start_tx    = 1'b0;
    assign tx_data     = 8'h00;
    assign unused_echo = tx_busy ^ frame_ok;
`endif

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24000, meaning the inter-byte timeout in clk cycles (1 ms at 24 MHz).
REQ-002 SHALL have parameter ANGLE_MAX, default 3599, meaning the largest accepted angle code.
REQ-003 SHALL have port clk  input  1  meaning the single clock (24 MHz UART domain); all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  meaning the received byte from uart_rx.
REQ-006 SHALL have port rx_done  input  1  meaning the uart_rx byte-done level; may stay high for several cycles.
REQ-007 SHALL have port rx_parity_err  input  1  meaning the parity error flag, valid while rx_done is high.
REQ-008 SHALL have port period_start  input  1  meaning a one-cycle pulse at the modulator carrier-period boundary.
REQ-009 SHALL have port tx_busy  input  1  meaning uart_tx busy.
REQ-010 SHALL have port start_tx  output  1  meaning a one-cycle uart_tx start pulse.
REQ-011 SHALL have port tx_data  output  8  meaning the byte to transmit.
REQ-012 SHALL have port angle  output  12  meaning the angle applied to the modulator.
REQ-013 SHALL have port angle_upd  output  1  meaning a one-cycle pulse in the cycle angle changes.
REQ-014 SHALL have port out_en  output  1  meaning the gate-drive enable to the modulator.
REQ-015 SHALL have port frame_err  output  1  meaning a one-cycle pulse for each discarded frame.
REQ-016 SHALL have port err_count  output  8  meaning the count of discarded frames, saturating.

Function
REQ-017 SHALL detect a byte on the rising edge of rx_done (registered previous value); a level held high SHALL count as one byte.
REQ-018 SHALL frame commands as two bytes: byte0 = {cmd[3:0], arg[11:8]}, byte1 = arg[7:0].
REQ-019 SHALL run the receive FSM WAIT_HI -> WAIT_LO -> DECODE -> WAIT_HI; DECODE SHALL last exactly one cycle.
REQ-020 SHALL, in WAIT_LO, load a counter with TIMEOUT_CYCLES on entry and decrement it each cycle; at zero it SHALL discard the frame and return to WAIT_HI.
REQ-021 SHALL, for a byte with rx_parity_err=1 in either state, discard the frame and go to WAIT_HI.
REQ-022 SHALL decode cmd as follows: 0x0 set angle (arg <= ANGLE_MAX, else discard); 0x1 out_en<=1; 0x2 out_en<=0; all other values discard.
REQ-023 SHALL, on an accepted set-angle command, write arg to a shadow register and set pending.
REQ-024 SHALL, on the first period_start with pending=1, set angle<=shadow, pulse angle_upd, and clear pending; angle SHALL never change at any other time.
REQ-025 SHALL let a newer accepted set-angle command overwrite the shadow before it is applied (last writer wins).
REQ-026 SHALL, when an accept (DECODE) and period_start occur in the same cycle, apply the old shadow and keep pending set with the new value.
REQ-027 SHALL, on every discard, pulse frame_err once and increment err_count, saturating at 255.
REQ-028 SHALL change out_en in the DECODE cycle, with no period alignment.

Reset
REQ-029 SHALL, while reset is high, force: receive FSM=WAIT_HI, pending=0, shadow=0, angle=0, out_en=0, err_count=0, start_tx=0, tx_data=0, angle_upd=0, frame_err=0, echo FSM=E_IDLE.
REQ-030 SHALL abandon a partial frame or an echo in progress when reset asserts; after release the first rx_done rise SHALL be treated as byte0.

Configuration
REQ-031 SHALL compile the echo feature only when macro UART_CMD_ECHO_EN is defined.
REQ-032 SHALL, with UART_CMD_ECHO_EN defined, echo each accepted frame (byte0 then byte1) through echo FSM E_IDLE -> E_HI -> E_WAIT_HI -> E_LO -> E_WAIT_LO -> E_IDLE.
REQ-033 SHALL, in E_HI and E_LO, pulse start_tx for one cycle with tx_data set, only when tx_busy=0.
REQ-034 SHALL, in E_WAIT_HI and E_WAIT_LO, wait for tx_busy to rise and then fall.
REQ-035 SHALL skip the echo of a frame accepted while the echo FSM is not in E_IDLE; reception SHALL never stall.
REQ-036 SHALL, without UART_CMD_ECHO_EN, tie start_tx=0 and tx_data=0 and omit the echo FSM.

Verification
REQ-037 SHALL cover: bytes 0x01,0x2C then period_start -> angle=0x12C with one angle_upd in that cycle; no change before period_start.
REQ-038 SHALL cover: byte 0x10 then 0x00 -> out_en=1 in the DECODE cycle; byte 0x20 then 0x00 -> out_en=0.
REQ-039 SHALL cover: byte0 0x01, then no byte for TIMEOUT_CYCLES, then 0x05,0x00 -> timeout discard (frame_err, err_count=1); the next frame decodes as cmd 0, arg 0x500, set angle.
REQ-040 SHALL cover: bytes 0x0E,0x10 (arg 3600 > ANGLE_MAX) -> frame_err, angle unchanged; a parity error on byte1 -> discard; 300 discards -> err_count=255.
REQ-041 SHALL cover: two set-angle frames (0x064, then 0x0C8) before one period_start -> angle=0x0C8 with a single angle_upd; reset asserted mid-frame -> all outputs zero.
REQ-042 SHALL cover, with UART_CMD_ECHO_EN: frame 0x01,0x2C -> start_tx pulses with tx_data=0x01 then 0x2C, each gated on tx_busy low; a second frame during the echo is accepted but not echoed.
